input_debounce: RTL

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - 8-channel switch/button debouncer with 2-flop synchronizers.
// Optional step auto-repeat is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module input_debounce #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_raw,
    input  logic       step_raw,
    input  logic       valid_raw,
    input  logic [4:0] in_raw,
    output logic       run,
    output logic       step,
    output logic       valid,
    output logic [4:0] in,
    output logic [7:0] changed
);

    typedef enum logic [1:0] {S0, C1, S1, C0} db_state_t;

    localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

    logic [7:0] raw_vec;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] level;
    logic [7:0] chg;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic step_dip;
`endif

    assign raw_vec = {in_raw, valid_raw, step_raw, run_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_ch
        db_state_t   st;
        logic [19:0] cnt;
        logic [19:0] cnt_inc;
        logic        lvl;
        logic        pulse;

        assign cnt_inc = cnt + 20'd1;

        // The cycle that moves S0->C1 is the first stable sample, so the commit
        // happens when the incremented count lands on DB_CYCLES-1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st    <= S0;
                cnt   <= '0;
                lvl   <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (st)
                    S0: begin
                        if (sync2[g]) begin
                            cnt <= '0;
                            if (DB_CYCLES == 1) begin
                                st    <= S1;
                                lvl   <= 1'b1;
                                pulse <= 1'b1;
                            end else begin
                                st <= C1;
                            end
                        end
                    end
                    C1: begin
                        if (!sync2[g]) begin
                            st  <= S0;
                            cnt <= '0;
                        end else if (cnt_inc == DB_LAST) begin
                            st    <= S1;
                            cnt   <= '0;
                            lvl   <= 1'b1;
                            pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S1: begin
                        if (!sync2[g]) begin
                            cnt <= '0;
                            if (DB_CYCLES == 1) begin
                                st    <= S0;
                                lvl   <= 1'b0;
                                pulse <= 1'b1;
                            end else begin
                                st <= C0;
                            end
                        end
                    end
                    C0: begin
                        if (sync2[g]) begin
                            st  <= S1;
                            cnt <= '0;
                        end else if (cnt_inc == DB_LAST) begin
                            st    <= S0;
                            cnt   <= '0;
                            lvl   <= 1'b0;
                            pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        st  <= S0;
                        cnt <= '0;
                    end
                endcase
            end
        end

        assign level[g] = lvl;
        assign chg[g]   = pulse;

`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (g == 1) begin : g_rpt
            localparam logic [25:0] RD_LAST = 26'(RPT_DELAY - 1);
            localparam logic [25:0] RP_LAST = 26'(RPT_PERIOD - 1);

            logic [25:0] rpt_cnt;
            logic        rpt_on;

            // A dip already in progress is held through C0 so a release mid-dip
            // leaves step low; a bounce back to S1 clears it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rpt_cnt  <= '0;
                    rpt_on   <= 1'b0;
                    step_dip <= 1'b0;
                end else if (st == S1) begin
                    if (!rpt_on) begin
                        if (rpt_cnt == RD_LAST) begin
                            rpt_on   <= 1'b1;
                            rpt_cnt  <= '0;
                            step_dip <= 1'b1;
                        end else begin
                            rpt_cnt  <= rpt_cnt + 26'd1;
                            step_dip <= 1'b0;
                        end
                    end else begin
                        if (rpt_cnt == RP_LAST) begin
                            rpt_cnt  <= '0;
                            step_dip <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 26'd1;
                            if (rpt_cnt == 26'd1) begin
                                step_dip <= 1'b0;
                            end
                        end
                    end
                end else begin
                    rpt_cnt <= '0;
                    rpt_on  <= 1'b0;
                    if (!(st == C0 && !sync2[1])) begin
                        step_dip <= 1'b0;
                    end
                end
            end
        end
`endif
    end

    assign run = level[0];
`ifdef DEBOUNCE_AUTOREPEAT_EN
    assign step = level[1] & ~step_dip;
`else
    assign step = level[1];
`endif
    assign valid   = level[2];
    assign in      = level[7:3];
    assign changed = chg;

endmodule
